// File: rtl/key_car_pkg.sv
// Shared encodings and defaults for the key-driven smart-car controller.
package key_car_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_RAMP = 2'd2,
    ST_ESTOP     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DIR_FWD   = 2'd0,
    DIR_BACK  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  localparam int KEY_START = 0;
  localparam int KEY_UP    = 1;
  localparam int KEY_DN    = 2;
  localparam int KEY_DIR   = 3;

  localparam int SPEED_MAX_DEF = 7;
  localparam int DUTY_STEP_DEF = 32;
  localparam int RAMP_DIV_DEF  = 4;
  localparam int LONG_CNT_DEF  = 16;

  function automatic logic [7:0] duty_target(input logic [2:0] lvl, input int step);
    return 8'(int'(lvl) * step);
  endfunction

endpackage

// File: rtl/key_car_duty_ramp.sv
// Slews the PWM duty one unit toward its target every RAMP_DIV cycles.
// The divider free-runs, so a new target only changes direction, never phase.
module duty_ramp #(
  parameter int RAMP_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] target_i,
  input  logic       force_zero_i,
  output logic [7:0] duty_o
);

  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    duty_q, duty_d;
  logic          wrap;

  always_comb begin
    wrap   = (cnt_q == CW'(RAMP_DIV - 1));
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    duty_d = duty_q;
    if (force_zero_i) begin
      duty_d = '0;
    end else if (wrap) begin
      if (duty_q < target_i) begin
        duty_d = duty_q + 8'd1;
      end else if (duty_q > target_i) begin
        duty_d = duty_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      duty_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
    end
  end

  assign duty_o = duty_q;

endmodule

// File: rtl/key_car_ctrl.sv
// Turns debounced key events into run/stop state, speed, direction and a ramped duty.
// Every key event is reflected in the registered outputs one cycle later.
module key_car_ctrl
  import key_car_pkg::*;
#(
  parameter int SPEED_MAX = SPEED_MAX_DEF,
  parameter int DUTY_STEP = DUTY_STEP_DEF,
  parameter int RAMP_DIV  = RAMP_DIV_DEF,
  parameter int LONG_CNT  = LONG_CNT_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key_flag,
  input  logic [3:0] key_value,
  output logic       run_en,
  output logic [1:0] dir,
  output logic [2:0] speed_level,
  output logic [7:0] duty,
  output logic [1:0] state,
  output logic       cmd_reject
);

  localparam int HW = $clog2(LONG_CNT + 1);

  state_e       state_q, state_d;
  logic [1:0]   dir_q, dir_d;
  logic [2:0]   speed_q, speed_d;
  logic         rej_q, rej_d;
  logic         hold_act_q, hold_act_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  logic [3:0] press;
  logic       rel0, short0, long0;
  logic [7:0] target, duty_w;

  assign press = key_flag & ~key_value;
  assign rel0  = key_flag[KEY_START] & key_value[KEY_START];

  // Long press wins if the limit is reached in the same cycle as the release.
  always_comb begin
    hold_act_d = hold_act_q;
    hold_cnt_d = hold_cnt_q;
    short0     = 1'b0;
    long0      = 1'b0;
    if (press[KEY_START]) begin
      hold_act_d = 1'b1;
      hold_cnt_d = HW'(1);
    end else if (hold_act_q) begin
      if (hold_cnt_q == HW'(LONG_CNT)) begin
        long0      = 1'b1;
        hold_act_d = 1'b0;
        hold_cnt_d = '0;
      end else if (rel0) begin
        short0     = 1'b1;
        hold_act_d = 1'b0;
        hold_cnt_d = '0;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    dir_d   = dir_q;
    rej_d   = 1'b0;

    case (state_q)
      ST_IDLE:      if (short0) state_d = ST_RUN;
      ST_RUN:       if (short0) state_d = ST_STOP_RAMP;
      ST_STOP_RAMP: begin
        if (short0) begin
          state_d = ST_RUN;
        end else if (duty_w == 8'd0) begin
          state_d = ST_IDLE;
        end
      end
      ST_ESTOP:     if (rel0) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (long0) state_d = ST_ESTOP;

    if (state_q == ST_ESTOP) begin
      rej_d = press[KEY_UP] | press[KEY_DN] | press[KEY_DIR];
    end else begin
      if (press[KEY_UP] && press[KEY_DN]) begin
        rej_d = 1'b1;
      end else if (press[KEY_UP]) begin
        if (speed_q == 3'(SPEED_MAX)) rej_d = 1'b1;
        else speed_d = speed_q + 3'd1;
      end else if (press[KEY_DN]) begin
        if (speed_q == 3'd0) rej_d = 1'b1;
        else speed_d = speed_q - 3'd1;
      end
      if (press[KEY_DIR]) begin
        if (state_q == ST_IDLE) dir_d = dir_q + 2'd1;
        else rej_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      speed_q    <= 3'd1;
      dir_q      <= DIR_FWD;
      rej_q      <= 1'b0;
      hold_act_q <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      speed_q    <= speed_d;
      dir_q      <= dir_d;
      rej_q      <= rej_d;
      hold_act_q <= hold_act_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign target = (state_q == ST_RUN) ? duty_target(speed_q, DUTY_STEP) : 8'd0;

  duty_ramp #(
    .RAMP_DIV(RAMP_DIV)
  ) u_duty_ramp (
    .clk_i       (sys_clk),
    .rst_ni      (sys_rst_n),
    .target_i    (target),
    .force_zero_i(state_q == ST_ESTOP),
    .duty_o      (duty_w)
  );

  assign run_en      = (state_q == ST_RUN) || (state_q == ST_STOP_RAMP);
  assign dir         = dir_q;
  assign speed_level = speed_q;
  assign duty        = duty_w;
  assign state       = state_q;
  assign cmd_reject  = rej_q;

endmodule

// File: tb/tb_key_car_ctrl.sv
// Directed bench for key_car_ctrl: inputs change 1 ns after each rising edge, outputs checked there.
module tb_key_car_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] key_flag = 4'h0;
  logic [3:0] key_value = 4'hF;
  logic       run_en;
  logic [1:0] dir;
  logic [2:0] speed_level;
  logic [7:0] duty;
  logic [1:0] state;
  logic       cmd_reject;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 sys_clk = ~sys_clk;

  key_car_ctrl dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_flag   (key_flag),
    .key_value  (key_value),
    .run_en     (run_en),
    .dir        (dir),
    .speed_level(speed_level),
    .duty       (duty),
    .state      (state),
    .cmd_reject (cmd_reject)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle event on the keys in flags; vals gives their new levels.
  task automatic ev(input logic [3:0] flags, input logic [3:0] vals);
    key_value = (key_value & ~flags) | (vals & flags);
    key_flag  = flags;
    tick();
    key_flag  = 4'h0;
  endtask

  task automatic wait_duty(input logic [7:0] want, input int budget, output int cyc);
    cyc = 0;
    while (duty !== want && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    check("rst_state", state, 0);
    check("rst_run_en", run_en, 0);
    check("rst_dir", dir, 0);
    check("rst_speed", speed_level, 1);
    check("rst_duty", duty, 0);
    check("rst_reject", cmd_reject, 0);
    sys_rst_n = 1'b1;
    tick();

    // Short key0 starts the car; duty ramps 0 -> 32
    ev(4'b0001, 4'b0000);
    check("idle_during_press", state, 0);
    tick();
    tick();
    ev(4'b0001, 4'b0001);
    check("run_after_short", state, 1);
    check("run_en_run", run_en, 1);
    wait_duty(8'd32, 200, n);
    check("duty_reach_32", duty, 32);
    check("ramp_up_cycles_125_128", (n >= 125 && n <= 128), 1);
    repeat (20) tick();
    check("duty_hold_32", duty, 32);

    // Speed up to level 4, duty to 128
    for (int i = 0; i < 3; i++) begin
      ev(4'b0010, 4'b0000);
      check("up_no_reject", cmd_reject, 0);
      ev(4'b0010, 4'b0010);
    end
    check("speed_4", speed_level, 4);
    wait_duty(8'd128, 500, n);
    check("duty_reach_128", duty, 128);

    // Short key0 in RUN -> STOP_RAMP, ramp down to 0 then IDLE
    ev(4'b0001, 4'b0000);
    tick();
    ev(4'b0001, 4'b0001);
    check("stop_ramp_state", state, 2);
    check("stop_ramp_run_en", run_en, 1);
    wait_duty(8'd0, 600, n);
    check("duty_reach_0", duty, 0);
    check("ramp_down_cycles_509_512", (n >= 509 && n <= 512), 1);
    check("still_stop_ramp", state, 2);
    tick();
    check("idle_after_ramp", state, 0);
    check("run_en_idle", run_en, 0);

    // Speed saturation at 7 (in IDLE)
    for (int i = 0; i < 3; i++) begin
      ev(4'b0010, 4'b0000);
      ev(4'b0010, 4'b0010);
    end
    check("speed_7", speed_level, 7);
    ev(4'b0010, 4'b0000);
    check("speed_sat_7", speed_level, 7);
    check("reject_sat_up", cmd_reject, 1);
    ev(4'b0010, 4'b0010);
    check("reject_pulse_ends", cmd_reject, 0);

    // Direction cycling in IDLE, rejected in RUN
    for (int i = 1; i <= 4; i++) begin
      ev(4'b1000, 4'b0000);
      check("dir_step", dir, i % 4);
      check("dir_no_reject", cmd_reject, 0);
      ev(4'b1000, 4'b1000);
    end
    ev(4'b0001, 4'b0000);
    ev(4'b0001, 4'b0001);
    check("run_again", state, 1);
    ev(4'b1000, 4'b0000);
    check("dir_locked_run", dir, 0);
    check("reject_dir_run", cmd_reject, 1);
    ev(4'b1000, 4'b1000);

    // Down to level 3, then simultaneous up+down
    for (int i = 0; i < 4; i++) begin
      ev(4'b0100, 4'b0000);
      ev(4'b0100, 4'b0100);
    end
    check("speed_3", speed_level, 3);
    ev(4'b0110, 4'b0000);
    check("updn_speed_3", speed_level, 3);
    check("reject_updn", cmd_reject, 1);
    ev(4'b0110, 4'b0110);

    // Long key0 -> ESTOP
    repeat (40) tick();
    check("duty_nonzero_run", (duty != 8'd0), 1);
    ev(4'b0001, 4'b0000);
    repeat (15) tick();
    check("no_long_yet", state, 1);
    tick();
    check("estop_state", state, 3);
    check("estop_run_en", run_en, 0);
    tick();
    check("estop_duty_0", duty, 0);
    ev(4'b0010, 4'b0000);
    check("estop_reject_up", cmd_reject, 1);
    check("estop_speed_kept", speed_level, 3);
    ev(4'b0010, 4'b0010);
    ev(4'b0001, 4'b0001);
    check("estop_exit_idle", state, 0);
    check("estop_exit_run_en", run_en, 0);
    tick();
    check("no_run_toggle", state, 0);
    ev(4'b1000, 4'b0000);
    check("dir_1_again", dir, 1);
    ev(4'b1000, 4'b1000);

    // Release at hold count 15 is still a short press
    ev(4'b0001, 4'b0000);
    repeat (14) tick();
    ev(4'b0001, 4'b0001);
    check("short_at_15", state, 1);

    // Reset mid-ramp, with a pending key event
    repeat (30) tick();
    check("duty_mid_ramp", (duty != 8'd0), 1);
    sys_rst_n = 1'b0;
    ev(4'b1000, 4'b0000);
    check("mid_rst_state", state, 0);
    check("mid_rst_run_en", run_en, 0);
    check("mid_rst_dir", dir, 0);
    check("mid_rst_speed", speed_level, 1);
    check("mid_rst_duty", duty, 0);
    check("mid_rst_reject", cmd_reject, 0);
    sys_rst_n = 1'b1;
    tick();
    ev(4'b1000, 4'b1000);

    // Down saturation at 0
    ev(4'b0100, 4'b0000);
    check("speed_0", speed_level, 0);
    check("dn_no_reject", cmd_reject, 0);
    ev(4'b0100, 4'b0100);
    ev(4'b0100, 4'b0000);
    check("speed_sat_0", speed_level, 0);
    check("reject_sat_dn", cmd_reject, 1);
    ev(4'b0100, 4'b0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
